dll_trunc_index_gen: RTL

Automatic truncation-index generator for the DLL/PLL correlator path: it watches the 19-bit signed dump values that feed `dll_truncate` and produces the 5-bit `index` that `dll_truncate` uses to pick its 9-bit window. Once per window of `DUMP_WINDOW` dumps it tracks the peak magnitude, finds its leading one and updates the index, with an asymmetric step rule: fast attack, slow release. It also flags every dump that the current index would clip.

---
 rtl/dll_trunc_index_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dll_trunc_index_gen.sv
// -----------------------------------------------------------------------------
// dll_trunc_index_gen
//
// Watches the 19-bit signed correlator dump values that feed dll_truncate and
// generates the 5-bit truncation index that selects dll_truncate's 9-bit
// window. Once per window of DUMP_WINDOW dumps, the peak magnitude is reduced
// to its leading-one position and the index is updated. The update attacks
// quickly, jumping straight up to the target. It releases slowly, stepping
// down by one per window. Every dump that the current index would clip is
// flagged on sat_event.
//
// Parameters
//   DUMP_WINDOW  dumps per evaluation window, legal 1..255
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   dump_valid   one-cycle strobe, in is valid this cycle
//   in           19-bit signed two's-complement dump value
//   index        current truncation index, 9..18, registered
//   index_valid  one-cycle pulse on the cycle after index was re-evaluated
//   sat_event    one-cycle pulse: the previous dump did not fit index+1 bits
// -----------------------------------------------------------------------------
module dll_trunc_index_gen #(
  parameter int unsigned DUMP_WINDOW = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dump_valid,
  input  logic [18:0] in,
  output logic [4:0]  index,
  output logic        index_valid,
  output logic        sat_event
);

  localparam logic [7:0] WIN = 8'(DUMP_WINDOW);

  typedef enum logic {
    ACCUM,
    EVAL
  } state_t;

  state_t      state, state_nxt;
  logic [18:0] peak, peak_nxt;
  logic [7:0]  count, count_nxt;
  logic [4:0]  index_nxt;
  logic [18:0] mag;
  logic [4:0]  lead_pos;
  logic [4:0]  target;
  logic        clip;

  // Magnitude of the dump. The most negative value has no positive twin in
  // 19 bits, so it saturates to the largest positive magnitude.
  always_comb begin
    if (!in[18]) begin
      mag = in;
    end else if (in[17:0] == '0) begin
      mag = 19'h3_FFFF;
    end else begin
      mag = -in;
    end
  end

  // Leading-one position of the window peak. The ascending loop leaves the
  // highest set bit. A zero peak reports position 0.
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < 19; i++) begin
      if (peak[i]) lead_pos = 5'(i);
    end
  end

  // target = clamp(lead_pos + 1, 9, 18)
  always_comb begin
    if (lead_pos >= 5'd17) begin
      target = 5'd18;
    end else if (lead_pos <= 5'd8) begin
      target = 5'd9;
    end else begin
      target = lead_pos + 5'd1;
    end
  end

  // The dump fits index+1 signed bits only when every bit from index up to
  // the sign bit is a copy of the sign. The check uses the index that is
  // present in the dump cycle.
  always_comb begin
    clip = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if ((5'(i) >= index) && (in[i] != in[18])) clip = 1'b1;
    end
  end

  // Next-state logic. Peak and count start from scratch in EVAL, but a dump
  // landing in that cycle opens the next window. With a one-dump window that
  // same dump completes the new window at once, so EVAL is re-entered.
  always_comb begin
    // NOTE: every signal driven here gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    state_nxt = state;
    peak_nxt  = peak;
    count_nxt = count;
    index_nxt = index;
    case (state)
      ACCUM: begin
        if (dump_valid) begin
          peak_nxt  = (mag > peak) ? mag : peak;
          count_nxt = count + 8'd1;
          if (count_nxt == WIN) state_nxt = EVAL;
        end
      end
      EVAL: begin
        if (target > index) begin
          index_nxt = target;
        end else if (target < index) begin
          index_nxt = index - 5'd1;
        end
        peak_nxt  = '0;
        count_nxt = '0;
        state_nxt = ACCUM;
        if (dump_valid) begin
          peak_nxt  = mag;
          count_nxt = 8'd1;
          if (WIN == 8'd1) state_nxt = EVAL;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // NOTE: the state registers use non-blocking assignments, so every register
  // samples the pre-edge values no matter how the statements are ordered. The
  // reset is in the sensitivity list, so it clears the registers without
  // waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ACCUM;
      peak        <= '0;
      count       <= '0;
      index       <= 5'd18;
      index_valid <= 1'b0;
      sat_event   <= 1'b0;
    end else begin
      state       <= state_nxt;
      peak        <= peak_nxt;
      count       <= count_nxt;
      index       <= index_nxt;
      index_valid <= (state == EVAL);
      sat_event   <= dump_valid & clip;
    end
  end

endmodule
